// File: rtl/cam_frame_writer_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | cam_frame_writer_if                                                  |
// | Camera FIFO read port plus SDRAM burst-write port of the writer.     |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
interface cam_frame_writer_if #(
   parameter int ADDR_W = 22
);
   logic [9:0]        fifo_count;
   logic [15:0]       fifo_dout;
   logic              fifo_rd_en;
   logic              wr_req;
   logic [ADDR_W-1:0] wr_addr;
   logic              wr_ack;
   logic              wr_pull;
   logic [15:0]       wr_data;

   modport master (
      input  fifo_count, fifo_dout, wr_ack, wr_pull,
      output fifo_rd_en, wr_req, wr_addr, wr_data
   );

   modport slave (
      output fifo_count, fifo_dout, wr_ack, wr_pull,
      input  fifo_rd_en, wr_req, wr_addr, wr_data
   );
endinterface
`default_nettype wire

// File: rtl/cam_frame_writer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | cam_frame_writer                                                     |
// | Drains the camera pixel FIFO into SDRAM as fixed-length bursts with  |
// | linear frame addressing. Optional CAM_FRAME_DOUBLE_BUFFER_EN adds    |
// | two frame banks and the rd_bank output.                              |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module cam_frame_writer #(
   parameter int BURST_LEN   = 512,
   parameter int FRAME_WORDS = 307200,
   parameter int ADDR_W      = 22,
   parameter int BASE_ADDR   = 0
) (
   input  wire logic          clk,
   input  wire logic          rst,
   input  wire logic          enable,
   input  wire logic          frame_sync,
   cam_frame_writer_if.master bus,
   output logic               frame_done,
   output logic               overflow
`ifdef CAM_FRAME_DOUBLE_BUFFER_EN
   ,
   output logic               rd_bank
`endif
);

   localparam int                CNT_W       = $clog2(BURST_LEN + 1);
   localparam logic [ADDR_W-1:0] C_BASE      = ADDR_W'(BASE_ADDR);
   localparam logic [ADDR_W-1:0] C_BURST     = ADDR_W'(BURST_LEN);
   localparam logic [ADDR_W-1:0] C_FRAME     = ADDR_W'(FRAME_WORDS);
   localparam logic [CNT_W-1:0]  C_BURST_CNT = CNT_W'(BURST_LEN);
   localparam logic [9:0]        C_THRESH    = 10'(BURST_LEN);
   localparam logic [9:0]        C_FIFO_FULL = 10'd1023;

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_WAIT_FILL = 3'd1,
      S_REQ       = 3'd2,
      S_XFER      = 3'd3,
      S_FINISH    = 3'd4
   } state_t;

   state_t            r_state;
   logic [ADDR_W-1:0] r_offset;
   logic [CNT_W-1:0]  r_pull_cnt;
   logic              r_sync_pending;
   logic              r_rd_d;
   logic              r_wr_req;
   logic [ADDR_W-1:0] r_wr_addr;
   logic              r_frame_done;
   logic              r_overflow;

   logic              w_rd_en;
   logic [ADDR_W-1:0] w_offset_inc;
   logic              w_wrap;
   logic [ADDR_W-1:0] w_bank_base;

`ifdef CAM_FRAME_DOUBLE_BUFFER_EN
   logic              r_bank;
   logic              r_rd_bank;
   assign w_bank_base = r_bank ? C_FRAME : '0;
   assign rd_bank     = r_rd_bank;
`else
   assign w_bank_base = '0;
`endif

   // Reads are gated by the burst count so surplus pulls never touch the FIFO.
   assign w_rd_en      = (r_state == S_XFER) && bus.wr_pull && (r_pull_cnt < C_BURST_CNT);
   assign w_offset_inc = r_offset + C_BURST;
   assign w_wrap       = (w_offset_inc >= C_FRAME);

   assign bus.fifo_rd_en = w_rd_en;
   assign bus.wr_req     = r_wr_req;
   assign bus.wr_addr    = r_wr_addr;
   // FIFO data passes straight through; zero outside valid read slots.
   assign bus.wr_data    = r_rd_d ? bus.fifo_dout : 16'h0000;
   assign frame_done     = r_frame_done;
   assign overflow       = r_overflow;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state        <= S_IDLE;
         r_offset       <= '0;
         r_pull_cnt     <= '0;
         r_sync_pending <= 1'b0;
         r_rd_d         <= 1'b0;
         r_wr_req       <= 1'b0;
         r_wr_addr      <= C_BASE;
         r_frame_done   <= 1'b0;
         r_overflow     <= 1'b0;
`ifdef CAM_FRAME_DOUBLE_BUFFER_EN
         r_bank         <= 1'b0;
         r_rd_bank      <= 1'b0;
`endif
      end else begin
         r_frame_done <= 1'b0;
         r_rd_d       <= w_rd_en;
         if (frame_sync && (bus.fifo_count == C_FIFO_FULL)) begin
            r_overflow <= 1'b1;
         end

         case (r_state)
            S_IDLE: begin
               if (frame_sync) r_offset <= '0;
               if (enable) r_state <= S_WAIT_FILL;
            end

            S_WAIT_FILL: begin
               if (frame_sync) r_offset <= '0;
               if (!enable) begin
                  r_state <= S_IDLE;
               end else if (bus.fifo_count >= C_THRESH) begin
                  r_state <= S_REQ;
               end
            end

            S_REQ: begin
               if (frame_sync) r_sync_pending <= 1'b1;
               r_wr_addr <= C_BASE + w_bank_base + r_offset;
               // Ack only counts once the request is actually visible.
               if (bus.wr_ack && r_wr_req) begin
                  r_wr_req   <= 1'b0;
                  r_pull_cnt <= '0;
                  r_state    <= S_XFER;
               end else begin
                  r_wr_req <= 1'b1;
               end
            end

            S_XFER: begin
               if (frame_sync) r_sync_pending <= 1'b1;
               if (w_rd_en) r_pull_cnt <= r_pull_cnt + 1'b1;
               if (r_pull_cnt == C_BURST_CNT) r_state <= S_FINISH;
            end

            S_FINISH: begin
               r_state        <= S_WAIT_FILL;
               r_sync_pending <= 1'b0;
               // A wrap and a pending sync both land on zero; only the wrap signals a frame.
               if (w_wrap) begin
                  r_offset     <= '0;
                  r_frame_done <= 1'b1;
`ifdef CAM_FRAME_DOUBLE_BUFFER_EN
                  r_rd_bank    <= r_bank;
                  r_bank       <= ~r_bank;
`endif
               end else if (r_sync_pending || frame_sync) begin
                  r_offset <= '0;
               end else begin
                  r_offset <= w_offset_inc;
               end
            end

            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule
`default_nettype wire
